// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace checker: golden entry layout,
// failure cause encodings and the run-control state type.
package wb_trace_pkg;

    localparam int ENTRY_W = 69;
    localparam int PC_LSB  = 37;
    localparam int REG_LSB = 32;

    localparam logic [1:0] FC_NONE      = 2'd0;
    localparam logic [1:0] FC_MISMATCH  = 2'd1;
    localparam logic [1:0] FC_TIMEOUT   = 2'd2;
    localparam logic [1:0] FC_UNDERFLOW = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [31:0] entry_pc(input logic [ENTRY_W-1:0] e);
        return e[PC_LSB +: 32];
    endfunction

    function automatic logic [4:0] entry_reg(input logic [ENTRY_W-1:0] e);
        return e[REG_LSB +: 5];
    endfunction

    function automatic logic [31:0] entry_value(input logic [ENTRY_W-1:0] e);
        return e[31:0];
    endfunction

endpackage

// File: rtl/trace_prefetch_fifo.sv
// Two-entry golden-entry FIFO. When empty, a word being pushed is visible at
// the head in the same cycle so a pop can consume it directly.
module trace_prefetch_fifo
    import wb_trace_pkg::*;
#(
    parameter int W = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ,
    output logic         o_avail
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_occ;
    logic         w_store;
    logic         w_take;
    logic         w_empty;

    assign w_empty = (r_occ == 2'd0);
    // A pop against an empty buffer consumes the incoming word, so nothing is stored.
    assign w_store = i_push && !(i_pop && w_empty);
    assign w_take  = i_pop && !w_empty;

    assign o_head  = w_empty ? i_data : r_mem[r_rd];
    assign o_avail = !w_empty || i_push;
    assign o_occ   = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_occ <= 2'd0;
        end else if (i_flush) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_occ <= 2'd0;
        end else begin
            if (w_store) r_wr <= ~r_wr;
            if (w_take)  r_rd <= ~r_rd;
            r_occ <= r_occ + 2'(w_store) - 2'(w_take);
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares qualifying writeback register writes against a golden trace held in
// a synchronous-read memory, reporting pass/fail, first mismatch and progress.
module wb_trace_checker
    import wb_trace_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 65536
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W:0]     trace_len,
    input  logic                wb_have_inst,
    input  logic [31:0]         wb_pc,
    input  logic                wb_ena,
    input  logic [4:0]          wb_reg,
    input  logic [31:0]         wb_value,
    output logic [ADDR_W-1:0]   ref_addr,
    output logic                ref_en,
    input  logic [ENTRY_W-1:0]  ref_rdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          fail_cause,
    output logic [ADDR_W:0]     err_index,
    output logic [31:0]         err_pc,
    output logic [31:0]         err_exp_value,
    output logic [31:0]         err_got_value,
    output logic [ADDR_W:0]     checked_count
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_addr, w_addr_nxt;
    logic               r_inflight;
    logic [TO_W-1:0]    r_to, w_to_nxt;
    logic               r_done, w_done_nxt;
    logic               r_pass, w_pass_nxt;
    logic [1:0]         r_cause, w_cause_nxt;
    logic [LEN_W-1:0]   r_eidx, w_eidx_nxt;
    logic [31:0]        r_epc, w_epc_nxt;
    logic [31:0]        r_eexp, w_eexp_nxt;
    logic [31:0]        r_egot, w_egot_nxt;
    logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;

    logic               w_busy;
    logic               w_qual;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_issue;
    logic               w_avail;
    logic               w_match;
    logic [1:0]         w_occ;
    logic [1:0]         w_slots;
    logic [ENTRY_W-1:0] w_head;
    logic [LEN_W-1:0]   w_fill_target;
    logic [LEN_W-1:0]   w_cnt_inc;

    assign w_busy  = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_qual  = wb_have_inst && wb_ena && (wb_reg != 5'd0);
    // Read data lands exactly one cycle after ref_en; drop it once the run has ended.
    assign w_push  = r_inflight && w_busy;
    assign w_pop   = w_busy && w_qual && w_avail;
    assign w_flush = start && !w_busy;
    assign w_slots = w_occ + 2'(r_inflight);
    assign w_issue = w_busy && (w_slots < 2'd2) && (r_addr < r_len);

    assign w_fill_target = (r_len > LEN_W'(2)) ? LEN_W'(2) : r_len;
    assign w_cnt_inc     = r_cnt + LEN_W'(1);
    assign w_match       = (entry_pc(w_head) == wb_pc) &&
                           (entry_reg(w_head) == wb_reg) &&
                           (entry_value(w_head) == wb_value);

    trace_prefetch_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (ref_rdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_occ   (w_occ),
        .o_avail (w_avail)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_addr_nxt  = r_addr;
        w_to_nxt    = r_to;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_cause_nxt = r_cause;
        w_eidx_nxt  = r_eidx;
        w_epc_nxt   = r_epc;
        w_eexp_nxt  = r_eexp;
        w_egot_nxt  = r_egot;
        w_cnt_nxt   = r_cnt;

        if (w_issue) w_addr_nxt = r_addr + LEN_W'(1);

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_len_nxt   = trace_len;
                    w_addr_nxt  = '0;
                    w_to_nxt    = '0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_cause_nxt = FC_NONE;
                    w_eidx_nxt  = '0;
                    w_epc_nxt   = '0;
                    w_eexp_nxt  = '0;
                    w_egot_nxt  = '0;
                    w_cnt_nxt   = '0;
                    if (trace_len == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL, S_RUN: begin
                // Once the initial reads are issued, the last of them returns this cycle.
                if ((r_state == S_FILL) && (r_addr >= w_fill_target)) w_state_nxt = S_RUN;

                if (w_qual) begin
                    // A write arriving before the buffer is primed is checked like any other.
                    w_to_nxt = '0;
                    if (!w_avail) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_cause_nxt = FC_UNDERFLOW;
                        w_eidx_nxt  = r_cnt;
                        w_epc_nxt   = wb_pc;
                        w_egot_nxt  = wb_value;
                    end else if (w_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_cause_nxt = FC_MISMATCH;
                        w_eidx_nxt  = r_cnt;
                        w_epc_nxt   = wb_pc;
                        w_eexp_nxt  = entry_value(w_head);
                        w_egot_nxt  = wb_value;
                    end
                end else if (r_state == S_RUN) begin
                    w_to_nxt = r_to + TO_W'(1);
                    if (r_to == TO_W'(TIMEOUT - 1)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_cause_nxt = FC_TIMEOUT;
                        w_eidx_nxt  = r_cnt;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_to       <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_cause    <= FC_NONE;
            r_eidx     <= '0;
            r_epc      <= '0;
            r_eexp     <= '0;
            r_egot     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_addr     <= w_addr_nxt;
            r_inflight <= w_issue;
            r_to       <= w_to_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_cause    <= w_cause_nxt;
            r_eidx     <= w_eidx_nxt;
            r_epc      <= w_epc_nxt;
            r_eexp     <= w_eexp_nxt;
            r_egot     <= w_egot_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign ref_addr      = r_addr[ADDR_W-1:0];
    assign ref_en        = w_issue;
    assign busy          = w_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail_cause    = r_cause;
    assign err_index     = r_eidx;
    assign err_pc        = r_epc;
    assign err_exp_value = r_eexp;
    assign err_got_value = r_egot;
    assign checked_count = r_cnt;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed and randomized bench for wb_trace_checker with a golden-memory model
// and an in-order trace reference.
module tb_wb_trace_checker;

    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   trace_len;
    logic          wb_have_inst;
    logic [31:0]   wb_pc;
    logic          wb_ena;
    logic [4:0]    wb_reg;
    logic [31:0]   wb_value;
    logic [AW-1:0] ref_addr;
    logic          ref_en;
    logic [68:0]   ref_rdata = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    fail_cause;
    logic [AW:0]   err_index;
    logic [31:0]   err_pc;
    logic [31:0]   err_exp_value;
    logic [31:0]   err_got_value;
    logic [AW:0]   checked_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] g_pc  [256];
    logic [4:0]  g_reg [256];
    logic [31:0] g_val [256];

    logic        e_have [256];
    logic        e_ena  [256];
    logic [4:0]  e_reg  [256];
    logic [31:0] e_pc   [256];
    logic [31:0] e_val  [256];

    wb_trace_checker #(
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .trace_len     (trace_len),
        .wb_have_inst  (wb_have_inst),
        .wb_pc         (wb_pc),
        .wb_ena        (wb_ena),
        .wb_reg        (wb_reg),
        .wb_value      (wb_value),
        .ref_addr      (ref_addr),
        .ref_en        (ref_en),
        .ref_rdata     (ref_rdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_cause    (fail_cause),
        .err_index     (err_index),
        .err_pc        (err_pc),
        .err_exp_value (err_exp_value),
        .err_got_value (err_got_value),
        .checked_count (checked_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ref_en) ref_rdata <= {g_pc[ref_addr], g_reg[ref_addr], g_val[ref_addr]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wb_have_inst = 1'b0;
        wb_ena       = 1'b0;
        wb_reg       = 5'd0;
        wb_pc        = '0;
        wb_value     = '0;
    endtask

    task automatic ev(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] v);
        wb_have_inst = 1'b1;
        wb_ena       = 1'b1;
        wb_pc        = pc;
        wb_reg       = r;
        wb_value     = v;
        tick();
        idle_in();
    endtask

    task automatic begin_run(input int len);
        trace_len = (AW+1)'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_result(input string t, input logic d, input logic p, input logic [1:0] c,
                                input int cnt);
        check({t, ".done"}, 64'(done), 64'(d));
        check({t, ".pass"}, 64'(pass), 64'(p));
        check({t, ".cause"}, 64'(fail_cause), 64'(c));
        check({t, ".count"}, 64'(checked_count), 64'(cnt));
    endtask

    task automatic load_basic();
        g_pc[0] = 32'h0; g_reg[0] = 5'd1; g_val[0] = 32'd5;
        g_pc[1] = 32'h4; g_reg[1] = 5'd2; g_val[1] = 32'd7;
        g_pc[2] = 32'h8; g_reg[2] = 5'd3; g_val[2] = 32'd12;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        trace_len = '0;
        idle_in();
        for (int i = 0; i < 256; i++) begin
            g_pc[i] = '0; g_reg[i] = '0; g_val[i] = '0;
        end
        repeat (3) tick();

        // Reset values
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.pass", 64'(pass), 64'd0);
        check("rst.cause", 64'(fail_cause), 64'd0);
        check("rst.count", 64'(checked_count), 64'd0);
        check("rst.ref_en", 64'(ref_en), 64'd0);
        check("rst.ref_addr", 64'(ref_addr), 64'd0);
        check("rst.err", {err_pc, err_got_value}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Matching trace, with a start pulse while busy that must be ignored
        load_basic();
        begin_run(3);
        check("t1.busy", 64'(busy), 64'd1);
        ev(32'h0, 5'd1, 32'd5);
        check("t1.count1", 64'(checked_count), 64'd1);
        start = 1'b1; trace_len = '0;
        ev(32'h4, 5'd2, 32'd7);
        start = 1'b0; trace_len = 9'd3;
        check("t1.notdone", 64'(done), 64'd0);
        ev(32'h8, 5'd3, 32'd12);
        check_result("t1", 1'b1, 1'b1, 2'd0, 3);
        check("t1.busy_end", 64'(busy), 64'd0);
        check("t1.ref_en_done", 64'(ref_en), 64'd0);

        // Value mismatch on entry 1
        begin_run(3);
        ev(32'h0, 5'd1, 32'd5);
        ev(32'h4, 5'd2, 32'd8);
        check_result("t2", 1'b1, 1'b0, 2'd1, 1);
        check("t2.idx", 64'(err_index), 64'd1);
        check("t2.pc", 64'(err_pc), 64'h4);
        check("t2.exp", 64'(err_exp_value), 64'd7);
        check("t2.got", 64'(err_got_value), 64'd8);
        ev(32'h8, 5'd3, 32'd12);
        check("t2.sticky_count", 64'(checked_count), 64'd1);

        // Non-qualifying cycles interleaved
        begin_run(3);
        ev(32'h0, 5'd1, 32'd5);
        wb_have_inst = 1'b1; wb_ena = 1'b1; wb_reg = 5'd0; wb_pc = 32'h4; wb_value = 32'd99;
        tick();
        wb_ena = 1'b0; wb_reg = 5'd2;
        tick();
        idle_in();
        ev(32'h4, 5'd2, 32'd7);
        wb_have_inst = 1'b0; wb_ena = 1'b1; wb_reg = 5'd3; wb_pc = 32'h8; wb_value = 32'd1;
        tick();
        idle_in();
        ev(32'h8, 5'd3, 32'd12);
        check_result("t3", 1'b1, 1'b1, 2'd0, 3);

        // Timeout TO cycles after the last qualifying event
        begin_run(3);
        ev(32'h0, 5'd1, 32'd5);
        repeat (TO - 1) tick();
        check("t4.early", 64'(done), 64'd0);
        tick();
        check_result("t4", 1'b1, 1'b0, 2'd2, 1);

        // Qualifying event on the cycle after start
        trace_len = 9'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        ev(32'h0, 5'd1, 32'd5);
        check_result("t5", 1'b1, 1'b0, 2'd3, 0);
        check("t5.got", 64'(err_got_value), 64'd5);

        // Zero-length trace
        trace_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_result("t6", 1'b1, 1'b1, 2'd0, 0);
        check("t6.busy", 64'(busy), 64'd0);

        // Reset mid-run then a fresh run
        begin_run(3);
        ev(32'h0, 5'd1, 32'd5);
        ev(32'h4, 5'd2, 32'd7);
        check("t7.count2", 64'(checked_count), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t7.rst_busy", 64'(busy), 64'd0);
        check("t7.rst_count", 64'(checked_count), 64'd0);
        check("t7.rst_ref_en", 64'(ref_en), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        begin_run(3);
        ev(32'h0, 5'd1, 32'd5);
        ev(32'h4, 5'd2, 32'd7);
        ev(32'h8, 5'd3, 32'd12);
        check_result("t7", 1'b1, 1'b1, 2'd0, 3);

        // Randomized traces against an in-order reference
        for (int run = 0; run < 8; run++) begin
            int len, n_ev, idx, bad_k, e_idx;
            logic mism;
            logic [31:0] x_pc, x_exp, x_got;
            string tg;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                g_pc[i]  = 32'h1000 + 32'(4 * i) + (32'($urandom_range(0, 3)) << 16);
                g_reg[i] = 5'($urandom_range(1, 31));
                g_val[i] = $urandom;
            end
            bad_k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            n_ev = 0;
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                for (int g = 0; g < gap; g++) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    e_have[n_ev] = (kind != 0);
                    e_ena[n_ev]  = (kind == 2) ? 1'b1 : ((kind == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
                    e_reg[n_ev]  = (kind == 2) ? 5'd0 : 5'($urandom_range(1, 31));
                    e_pc[n_ev]   = $urandom;
                    e_val[n_ev]  = $urandom;
                    n_ev++;
                end
                e_have[n_ev] = 1'b1; e_ena[n_ev] = 1'b1;
                e_pc[n_ev] = g_pc[i]; e_reg[n_ev] = g_reg[i]; e_val[n_ev] = g_val[i];
                if (i == bad_k) begin
                    case ($urandom_range(0, 2))
                        0: e_pc[n_ev] = g_pc[i] ^ 32'h4;
                        1: e_reg[n_ev] = 5'((int'(g_reg[i]) % 31) + 1);
                        default: e_val[n_ev] = g_val[i] ^ (32'd1 << $urandom_range(0, 31));
                    endcase
                end
                n_ev++;
            end

            idx = 0; mism = 1'b0; e_idx = 0; x_pc = '0; x_exp = '0; x_got = '0;
            for (int e = 0; e < n_ev; e++) begin
                if (e_have[e] && e_ena[e] && e_reg[e] != 5'd0 && !mism && idx < len) begin
                    if (e_pc[e] == g_pc[idx] && e_reg[e] == g_reg[idx] && e_val[e] == g_val[idx]) begin
                        idx++;
                    end else begin
                        mism = 1'b1; e_idx = idx;
                        x_pc = e_pc[e]; x_exp = g_val[idx]; x_got = e_val[e];
                    end
                end
            end

            begin_run(len);
            for (int e = 0; e < n_ev; e++) begin
                wb_have_inst = e_have[e]; wb_ena = e_ena[e]; wb_reg = e_reg[e];
                wb_pc = e_pc[e]; wb_value = e_val[e];
                tick();
            end
            idle_in();
            tg = $sformatf("rnd%0d", run);
            check_result(tg, 1'b1, !mism, mism ? 2'd1 : 2'd0, idx);
            if (mism) begin
                check({tg, ".idx"}, 64'(err_index), 64'(e_idx));
                check({tg, ".pc"}, 64'(err_pc), 64'(x_pc));
                check({tg, ".exp"}, 64'(err_exp_value), 64'(x_exp));
                check({tg, ".got"}, 64'(err_got_value), 64'(x_got));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
